block_ram_arbiter: RTL
======================

# block_ram_arbiter

Two-requester controller that shares one 1-cycle single-port block RAM (1-RW, registered read, write-first index shared by read and write). After reset it sequences a zero-clear of every RAM entry, then arbitrates per-cycle read/write requests from two clients and returns read data with a per-port response valid. It sits between the RAM instance and its clients, such as a cache tag/data array shared by fetch and fill.

## Interface
- `DATA_WIDTH`, 32, RAM word width.
- `INDEX_WIDTH`, 8, RAM address width; EntryCount = 1 << INDEX_WIDTH.

- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `req0Valid` / `req1Valid` in 1: request present on port 0 / 1.
- `req0Ready` / `req1Ready` out 1: request accepted this cycle when valid && ready.
- `req0Write` / `req1Write` in 1: 1 = write, 0 = read.
- `req0Index` / `req1Index` in INDEX_WIDTH: target entry.
- `req0WriteValue` / `req1WriteValue` in DATA_WIDTH: write data.
- `resp0Valid` / `resp1Valid` out 1: read data valid for port 0 / 1.
- `resp0Value` / `resp1Value` out DATA_WIDTH: read data.
- `ramIndex` out INDEX_WIDTH: RAM index.
- `ramWriteValue` out DATA_WIDTH: RAM write data.
- `ramWriteEnable` out 1: RAM write enable.
- `ramReadValue` in DATA_WIDTH: RAM registered read output.
- `initDone` out 1: clear sequence complete.

## Operation
- FSM states: INIT, RUN. Reset → INIT, clear counter = 0.
- INIT:
  - Drive ramWriteEnable=1, ramIndex=counter, ramWriteValue=0.
  - Both readies are 0.
  - Counter increments each cycle.
  - When counter == EntryCount-1, go to RUN next cycle. The counter does not wrap into a second pass.
- RUN: initDone=1.
  - Grant at most one request per cycle.
  - The granted request drives ramIndex, ramWriteValue and ramWriteEnable=req?Write combinationally in the grant cycle.
  - The ready of the granted port is 1; the other port's ready is 0.
- No grant in RUN: ramWriteEnable=0, ramIndex=0, ramWriteValue=0.
- Arbitration with only one port valid: grant that port.
- Arbitration with both ports valid: winner per Configuration.
- Readies may depend combinationally on both valids. A valid must not depend on its ready.
- Read response:
  - A port granted a read in cycle N asserts respXValid for exactly cycle N+1.
  - respXValue = ramReadValue in that cycle.
  - Writes produce no response.
  - Responses cannot be back-pressured; clients must sink them.
- respXValue mirrors ramReadValue at all times. It is meaningful only with respXValid.
- Write-then-read of the same index in consecutive cycles returns the new data.
- Read and write of the same index in one cycle is impossible (single grant).

## Timing
- Reset values: state INIT, counter 0, initDone 0, req0Ready/req1Ready 0, resp0Valid/resp1Valid 0, round-robin pointer favours port 0.
- During INIT (including while rst is high): ramWriteEnable=1, ramIndex=counter, ramWriteValue=0.
- Clear takes exactly EntryCount cycles after rst deasserts.
- initDone rises in cycle EntryCount, counted from the first cycle after rst deasserts (cycle 0). The first grant is possible in that same cycle.
- Read latency: 1 cycle, grant to respValid.
- Throughput: 1 request per cycle, sustained.
- Reset mid-operation:
  - Pending response valids clear immediately (asynchronously).
  - The FSM returns to INIT and the clear restarts from index 0.
  - An accepted-but-unanswered read is dropped.

## Configuration
- `BLOCK_RAM_ARBITER_ROUND_ROBIN_EN` defined:
  - On contention, grant the port favoured by a 1-bit pointer.
  - The pointer flips to favour the other port after every grant, contended or not.
  - The pointer resets to favour port 0.
- Undefined: fixed priority. Port 0 always wins contention; no pointer register exists.

## Test plan
- INIT clear, INDEX_WIDTH=4: release rst → 16 cycles of ramWriteEnable=1, ramIndex 0..15, data 0; initDone=1 in cycle 16; readies 0 before that.
- Read after init: port 0 reads index 5 → resp0Valid=1 next cycle with value 0; resp1Valid stays 0.
- Write/read back-to-back: port 1 writes 0xDEADBEEF to index 3, then reads index 3 the next cycle → resp1Valid with 0xDEADBEEF one cycle after the read grant.
- Contention, 4 cycles with both ports valid:
  - Fixed build: port 0 granted all 4 cycles.
  - Round-robin build: grants 0,1,0,1.
- Reset mid-operation: assert rst in the cycle after a port 0 read grant → resp0Valid low immediately; after release the clear restarts at index 0; a previously written nonzero entry reads 0 after initDone.
- Idle RUN with no valids → ramWriteEnable=0, no resp valids, and RAM contents unchanged over 10 cycles.

Source files
------------

// File: rtl/block_ram_arbiter_if.sv
// ============================================================================
// Module      : block_ram_arbiter_if
// Description : Client request/response and RAM-side signal bundle for
//               block_ram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface block_ram_arbiter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 8
);
    logic                   req0Valid;
    logic                   req0Ready;
    logic                   req0Write;
    logic [INDEX_WIDTH-1:0] req0Index;
    logic [DATA_WIDTH-1:0]  req0WriteValue;
    logic                   resp0Valid;
    logic [DATA_WIDTH-1:0]  resp0Value;

    logic                   req1Valid;
    logic                   req1Ready;
    logic                   req1Write;
    logic [INDEX_WIDTH-1:0] req1Index;
    logic [DATA_WIDTH-1:0]  req1WriteValue;
    logic                   resp1Valid;
    logic [DATA_WIDTH-1:0]  resp1Value;

    logic [INDEX_WIDTH-1:0] ramIndex;
    logic [DATA_WIDTH-1:0]  ramWriteValue;
    logic                   ramWriteEnable;
    logic [DATA_WIDTH-1:0]  ramReadValue;

    logic                   initDone;

    modport slave (
        input  req0Valid, req0Write, req0Index, req0WriteValue,
        input  req1Valid, req1Write, req1Index, req1WriteValue,
        input  ramReadValue,
        output req0Ready, resp0Valid, resp0Value,
        output req1Ready, resp1Valid, resp1Value,
        output ramIndex, ramWriteValue, ramWriteEnable,
        output initDone
    );

    modport master (
        output req0Valid, req0Write, req0Index, req0WriteValue,
        output req1Valid, req1Write, req1Index, req1WriteValue,
        output ramReadValue,
        input  req0Ready, resp0Valid, resp0Value,
        input  req1Ready, resp1Valid, resp1Value,
        input  ramIndex, ramWriteValue, ramWriteEnable,
        input  initDone
    );
endinterface

`default_nettype wire

// File: rtl/block_ram_arbiter.sv
// ============================================================================
// Module      : block_ram_arbiter
// Description : Clears a shared 1-RW block RAM after reset, then grants one of
//               two clients per cycle. Define BLOCK_RAM_ARBITER_ROUND_ROBIN_EN
//               for round-robin contention; default is fixed port-0 priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_ram_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    block_ram_arbiter_if.slave bus
);
    localparam logic [INDEX_WIDTH-1:0] c_last_index = '1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [INDEX_WIDTH-1:0] r_count;
    logic                   r_init_done;
    logic                   r_resp0_valid;
    logic                   r_resp1_valid;

    logic w_run;
    logic w_favour0;
    logic w_grant0;
    logic w_grant1;

    assign w_run = (r_state == ST_RUN);

`ifdef BLOCK_RAM_ARBITER_ROUND_ROBIN_EN
    logic r_rr_ptr;

    // Pointer toggles on every grant, so a lone requester also hands priority over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_grant0 || w_grant1) begin
            r_rr_ptr <= ~r_rr_ptr;
        end
    end

    assign w_favour0 = ~r_rr_ptr;
`else
    assign w_favour0 = 1'b1;
`endif

    assign w_grant0 = w_run && bus.req0Valid && (!bus.req1Valid || w_favour0);
    assign w_grant1 = w_run && bus.req1Valid && !w_grant0;

    assign bus.req0Ready  = w_grant0;
    assign bus.req1Ready  = w_grant1;
    assign bus.resp0Valid = r_resp0_valid;
    assign bus.resp1Valid = r_resp1_valid;
    assign bus.resp0Value = bus.ramReadValue;
    assign bus.resp1Value = bus.ramReadValue;
    assign bus.initDone   = r_init_done;

    always_comb begin
        bus.ramIndex       = '0;
        bus.ramWriteValue  = '0;
        bus.ramWriteEnable = 1'b0;
        if (!w_run) begin
            bus.ramIndex       = r_count;
            bus.ramWriteEnable = 1'b1;
        end else if (w_grant0) begin
            bus.ramIndex       = bus.req0Index;
            bus.ramWriteValue  = bus.req0WriteValue;
            bus.ramWriteEnable = bus.req0Write;
        end else if (w_grant1) begin
            bus.ramIndex       = bus.req1Index;
            bus.ramWriteValue  = bus.req1WriteValue;
            bus.ramWriteEnable = bus.req1Write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_INIT;
            r_count       <= '0;
            r_init_done   <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
        end else begin
            r_resp0_valid <= w_grant0 && !bus.req0Write;
            r_resp1_valid <= w_grant1 && !bus.req1Write;
            case (r_state)
                ST_INIT: begin
                    // Counter holds at the last index so the clear never starts a second pass.
                    if (r_count == c_last_index) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
